// File: rtl/canvas_pkg.sv
// Shared types and constants for the canvas pixel RAM write-port controller.
// Default canvas geometry matches the 8-bit x / 7-bit y RAM address space.
package canvas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STAMP,
    CLEAR
  } ctrl_state_t;

  localparam int CANVAS_W_DEF     = 256;
  localparam int CANVAS_H_DEF     = 128;
  localparam int STAMP_CYCLES_BIG = 9;

endpackage

// File: rtl/canvas_sweep_counter.sv
// Raster x/y counter: x runs 0..X_LAST, then wraps and bumps y; clr forces (0,0).
// Updates one step per enabled cycle; clr wins over en; last flags (X_LAST, Y_LAST).
module canvas_sweep_counter #(
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int X_LAST = 255,
  parameter int Y_LAST = 127
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] XL = XW'(X_LAST);
  localparam logic [YW-1:0] YL = YW'(Y_LAST);

  assign last = (x == XL) && (y == YL);

  always_ff @(posedge clk) begin
    if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == XL) begin
        x <= '0;
        y <= (y == YL) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/canvas_write_ctrl.sv
// Arbitrates the canvas RAM write port between brush stamps (1x1/3x3, clipped) and a full clear sweep.
// Writes are registered, one per cycle; brush requests stall (reqReady low) while busy or a clear is due.
module canvas_write_ctrl
  import canvas_pkg::*;
#(
  parameter int CANVAS_W = CANVAS_W_DEF,
  parameter int CANVAS_H = CANVAS_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [7:0] reqX,
  input  logic [7:0] reqY,
  input  logic [2:0] reqColor,
  input  logic       reqBig,
  input  logic       clearStart,
  input  logic [2:0] clearColor,
  output logic       wrEn,
  output logic [7:0] wrX,
  output logic [7:0] wrY,
  output logic [2:0] wrColor,
  output logic       busy,
  output logic       clearDone
);

  ctrl_state_t state;
  logic        pending;
  logic [2:0]  pend_color;
  logic        tail;
  logic [7:0]  cx, cy;
  logic [2:0]  color;
  logic        big;

  logic        in_idle, req_fire, clear_go, enter_clr;
  logic [2:0]  clear_col;
  logic [7:0]  src_x, src_y;
  logic [2:0]  src_color;
  logic        src_big;
  logic [9:0]  tx, ty;
  logic        t_in;

  logic [1:0]  sox, soy;
  logic        s_last, s_en, s_clr;
  logic [7:0]  clr_x;
  logic [6:0]  clr_y;
  logic        c_last, c_en, c_clr;

  assign in_idle   = (state == IDLE);
  assign reqReady  = in_idle && !pending && !clearStart;
  assign req_fire  = reqValid && reqReady;
  assign clear_go  = clearStart || pending;
  assign enter_clr = clear_go && (in_idle || (state == STAMP && tail));
  assign busy      = !in_idle || pending;
  assign clear_col = pending ? pend_color : clearColor;

  // While idle the first stamp pixel is built straight from the request so it lands in cycle N+1.
  assign src_x     = in_idle ? reqX : cx;
  assign src_y     = in_idle ? reqY : cy;
  assign src_color = in_idle ? reqColor : color;
  assign src_big   = in_idle ? reqBig : big;

  // Two spare high bits keep centre+offset-1 signed without wrapping at x=255.
  assign tx   = {2'b00, src_x} + {8'b0, sox} - {9'b0, src_big};
  assign ty   = {2'b00, src_y} + {8'b0, soy} - {9'b0, src_big};
  assign t_in = !tx[9] && (tx < 10'(CANVAS_W)) && !ty[9] && (ty < 10'(CANVAS_H));

  assign s_en  = (req_fire && reqBig) || (state == STAMP && !tail);
  assign s_clr = reset || (state == STAMP && tail);
  assign c_en  = enter_clr || (state == CLEAR && !tail);
  assign c_clr = reset || (state == CLEAR && tail);

  canvas_sweep_counter #(.XW(2), .YW(2), .X_LAST(2), .Y_LAST(2)) u_stamp_cnt (
    .clk(clk), .clr(s_clr), .en(s_en), .x(sox), .y(soy), .last(s_last)
  );

  canvas_sweep_counter #(.XW(8), .YW(7), .X_LAST(CANVAS_W-1), .Y_LAST(CANVAS_H-1)) u_clear_cnt (
    .clk(clk), .clr(c_clr), .en(c_en), .x(clr_x), .y(clr_y), .last(c_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      pend_color <= '0;
      tail       <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      color      <= '0;
      big        <= 1'b0;
      wrEn       <= 1'b0;
      wrX        <= '0;
      wrY        <= '0;
      wrColor    <= '0;
      clearDone  <= 1'b0;
    end else begin
      clearDone <= 1'b0;
      if (state == STAMP && clearStart && !pending) begin
        pending    <= 1'b1;
        pend_color <= clearColor;
      end
      if (enter_clr) begin
        state   <= CLEAR;
        pending <= 1'b0;
        color   <= clear_col;
        tail    <= c_last;
        wrEn    <= 1'b1;
        wrX     <= clr_x;
        wrY     <= {1'b0, clr_y};
        wrColor <= clear_col;
      end else begin
        case (state)
          IDLE: begin
            if (req_fire) begin
              state <= STAMP;
              cx    <= reqX;
              cy    <= reqY;
              color <= reqColor;
              big   <= reqBig;
              tail  <= !reqBig;
            end
            wrEn    <= req_fire && t_in;
            wrColor <= req_fire ? src_color : wrColor;
            if (req_fire && t_in) begin
              wrX <= tx[7:0];
              wrY <= ty[7:0];
            end
          end
          STAMP: begin
            if (!tail) begin
              tail    <= s_last;
              wrEn    <= t_in;
              wrColor <= src_color;
              if (t_in) begin
                wrX <= tx[7:0];
                wrY <= ty[7:0];
              end
            end else begin
              state <= IDLE;
              wrEn  <= 1'b0;
            end
          end
          CLEAR: begin
            if (!tail) begin
              tail    <= c_last;
              wrEn    <= 1'b1;
              wrX     <= clr_x;
              wrY     <= {1'b0, clr_y};
              wrColor <= color;
            end else begin
              state     <= IDLE;
              wrEn      <= 1'b0;
              clearDone <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            wrEn  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_canvas_write_ctrl.sv
// Bench for canvas_write_ctrl: directed and $urandom stimulus against a pixel-list reference model.
module tb_canvas_write_ctrl;
  import canvas_pkg::*;

  localparam int W = CANVAS_W_DEF;
  localparam int H = CANVAS_H_DEF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqValid = 1'b0, reqBig = 1'b0, clearStart = 1'b0;
  logic [7:0] reqX = '0, reqY = '0;
  logic [2:0] reqColor = '0, clearColor = '0;
  logic       reqReady, wrEn, busy, clearDone;
  logic [7:0] wrX, wrY;
  logic [2:0] wrColor;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {int x; int y; int c; int t;} wr_t;
  wr_t wq[$];
  wr_t exp_q[$];
  int  done_q[$];

  canvas_write_ctrl dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqX(reqX), .reqY(reqY), .reqColor(reqColor), .reqBig(reqBig),
    .clearStart(clearStart), .clearColor(clearColor),
    .wrEn(wrEn), .wrX(wrX), .wrY(wrY), .wrColor(wrColor),
    .busy(busy), .clearDone(clearDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrEn === 1'b1) wq.push_back('{int'(wrX), int'(wrY), int'(wrColor), cyc});
    if (clearDone === 1'b1) done_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixels a stamp should write, in dy-outer/dx-inner order; clipped slots still take a cycle.
  function automatic void model_stamp(input int cx, input int cy, input int c, input bit big, input int t0);
    int k;
    k = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (big || (dx == 0 && dy == 0)) begin
          if (cx + dx >= 0 && cx + dx < W && cy + dy >= 0 && cy + dy < H)
            exp_q.push_back('{cx + dx, cy + dy, c, t0 + k});
          k++;
        end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL reset_wrEn got=%b want=0", wrEn); end
    total++; if (wrX !== 8'd0 || wrY !== 8'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", wrX, wrY); end
    total++; if (wrColor !== 3'd0) begin bad++; $display("FAIL reset_color got=%0d want=0", wrColor); end
    total++; if (clearDone !== 1'b0) begin bad++; $display("FAIL reset_clearDone got=%b want=0", clearDone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", reqReady); end
    step();
  endtask

  task automatic test_single();
    wq.delete();
    reqValid = 1'b1; reqX = 8'd10; reqY = 8'd20; reqColor = 3'd3; reqBig = 1'b0;
    @(negedge clk);
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", reqReady); end
    step();
    reqValid = 1'b0;
    @(negedge clk);
    total++;
    if (wrEn !== 1'b1 || wrX !== 8'd10 || wrY !== 8'd20 || wrColor !== 3'd3) begin
      bad++; $display("FAIL single_write got=en%b (%0d,%0d) c%0d want=en1 (10,20) c3", wrEn, wrX, wrY, wrColor);
    end
    step();
    @(negedge clk);
    total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", wrEn); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", wq.size()); end
    step();
  endtask

  task automatic test_big(input int cx, input int cy, input int col);
    int hx, hy, tx, ty;
    bit inb;
    hx = -1; hy = -1;
    reqValid = 1'b1; reqX = 8'(cx); reqY = 8'(cy); reqColor = 3'(col); reqBig = 1'b1;
    @(negedge clk);
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL big_ready got=%b want=1", reqReady); end
    step();
    reqValid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tx = cx + (k % 3) - 1;
      ty = cy + (k / 3) - 1;
      inb = (tx >= 0 && tx < W && ty >= 0 && ty < H);
      @(negedge clk);
      total++; if (wrEn !== inb) begin bad++; $display("FAIL big_en slot%0d c(%0d,%0d) got=%b want=%b", k, cx, cy, wrEn, inb); end
      if (inb) begin
        total++;
        if (int'(wrX) != tx || int'(wrY) != ty || int'(wrColor) != col) begin
          bad++; $display("FAIL big_pix slot%0d got=(%0d,%0d) c%0d want=(%0d,%0d) c%0d", k, wrX, wrY, wrColor, tx, ty, col);
        end
        hx = tx; hy = ty;
      end else if (hx >= 0) begin
        total++;
        if (int'(wrX) != hx || int'(wrY) != hy) begin
          bad++; $display("FAIL big_hold slot%0d got=(%0d,%0d) want=(%0d,%0d)", k, wrX, wrY, hx, hy);
        end
      end
      step();
    end
    @(negedge clk);
    total++;
    if (reqReady !== 1'b1 || wrEn !== 1'b0) begin
      bad++; $display("FAIL big_end got=ready%b en%b want=ready1 en0", reqReady, wrEn);
    end
    step();
  endtask

  task automatic test_back_to_back(input int n, input bit mix);
    int acc[$];
    bit bigs[$];
    int budget, stalls, sp_err, errs;
    stalls = 0; sp_err = 0; errs = 0;
    wq.delete(); exp_q.delete();
    for (int i = 0; i < n; i++) begin
      reqValid = 1'b1;
      reqBig   = mix ? 1'($urandom_range(0, 1)) : 1'b0;
      reqX     = 8'($urandom_range(0, 255));
      reqY     = mix ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, H - 1));
      reqColor = 3'($urandom_range(0, 7));
      budget = 0;
      @(negedge clk);
      while (reqReady !== 1'b1 && budget < 40) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 40) stalls++;
      acc.push_back(cyc);
      bigs.push_back(reqBig);
      model_stamp(int'(reqX), int'(reqY), int'(reqColor), reqBig, cyc + 1);
      step();
    end
    reqValid = 1'b0;
    repeat (12) step();
    for (int i = 1; i < acc.size(); i++)
      if (acc[i] - acc[i-1] != (bigs[i-1] ? 10 : 2)) sp_err++;
    foreach (exp_q[i])
      if (i >= wq.size() || wq[i].x != exp_q[i].x || wq[i].y != exp_q[i].y ||
          wq[i].c != exp_q[i].c || wq[i].t != exp_q[i].t) errs++;
    total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stall mix%0d got=%0d want=0", mix, stalls); end
    total++; if (sp_err != 0) begin bad++; $display("FAIL b2b_spacing mix%0d got=%0d bad gaps want=0", mix, sp_err); end
    total++; if (wq.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count mix%0d got=%0d want=%0d", mix, wq.size(), exp_q.size()); end
    total++; if (errs != 0) begin bad++; $display("FAIL b2b_order mix%0d got=%0d wrong writes want=0", mix, errs); end
  endtask

  task automatic test_clear();
    int c, acc, errs;
    wq.delete(); done_q.delete();
    c = cyc; acc = -1; errs = 0;
    clearStart = 1'b1; clearColor = 3'd2;
    reqValid = 1'b1; reqX = 8'd5; reqY = 8'd6; reqColor = 3'd1; reqBig = 1'b0;
    @(negedge clk);
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL clear_priority got=%b want=0", reqReady); end
    step();
    clearStart = 1'b0; clearColor = 3'd0;
    for (int n = 0; n < 40000 && acc < 0; n++) begin
      @(negedge clk);
      if (reqReady === 1'b1) acc = cyc;
      step();
      if (acc >= 0) reqValid = 1'b0;
    end
    reqValid = 1'b0;
    repeat (3) step();
    for (int k = 0; k < W * H; k++)
      if (k >= wq.size() || wq[k].x != k % W || wq[k].y != k / W || wq[k].c != 2 || wq[k].t != c + 1 + k) errs++;
    total++; if (wq.size() != W * H + 1) begin bad++; $display("FAIL clear_count got=%0d want=%0d", wq.size(), W * H + 1); end
    total++; if (errs != 0) begin bad++; $display("FAIL clear_sweep got=%0d wrong writes want=0", errs); end
    total++;
    if (done_q.size() != 1 || done_q[0] != c + W * H + 1) begin
      bad++; $display("FAIL clear_done got=%0d pulses want=1 at cycle %0d", done_q.size(), c + W * H + 1);
    end
    total++; if (acc != c + W * H + 1) begin bad++; $display("FAIL clear_held_accept got=%0d want=%0d", acc, c + W * H + 1); end
    total++;
    if (wq.size() != W * H + 1 || wq[W*H].x != 5 || wq[W*H].y != 6 || wq[W*H].c != 1 || wq[W*H].t != acc + 1) begin
      bad++; $display("FAIL clear_held_write got=%0d entries want held pixel (5,6) c1 at %0d", wq.size(), acc + 1);
    end
  endtask

  task automatic test_clear_during_stamp();
    int c, errs;
    wq.delete(); exp_q.delete(); done_q.delete();
    c = cyc; errs = 0;
    reqValid = 1'b1; reqX = 8'd100; reqY = 8'd50; reqColor = 3'd4; reqBig = 1'b1;
    step();
    reqValid = 1'b0;
    while (cyc < c + 11 + 1500) begin
      clearStart = (cyc == c + 3) || (cyc == c + 10 + 500);
      clearColor = (cyc == c + 3) ? 3'd6 : 3'd7;
      step();
    end
    clearStart = 1'b0;
    model_stamp(100, 50, 4, 1'b1, c + 1);
    for (int k = 0; k <= 1500; k++) exp_q.push_back('{k % W, k / W, 6, c + 10 + k});
    foreach (exp_q[i])
      if (i >= wq.size() || wq[i].x != exp_q[i].x || wq[i].y != exp_q[i].y ||
          wq[i].c != exp_q[i].c || wq[i].t != exp_q[i].t) errs++;
    total++; if (wq.size() < exp_q.size()) begin bad++; $display("FAIL pend_count got=%0d want>=%0d", wq.size(), exp_q.size()); end
    total++; if (errs != 0) begin bad++; $display("FAIL pend_sequence got=%0d wrong writes want=0", errs); end
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL pend_no_restart got=%0d done pulses want=0", done_q.size()); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset_midclear();
    int c;
    wq.delete(); done_q.delete();
    c = cyc;
    clearStart = 1'b1; clearColor = 3'd1;
    step();
    clearStart = 1'b0;
    while (cyc < c + 1001) step();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (wrEn !== 1'b1 || int'(wrX) != 1000 % W || int'(wrY) != 1000 / W) begin
      bad++; $display("FAIL midclr_pixel got=en%b (%0d,%0d) want=en1 (%0d,%0d)", wrEn, wrX, wrY, 1000 % W, 1000 / W);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL midclr_wrEn got=%b want=0", wrEn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b want=0", busy); end
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL midclr_ready got=%b want=1", reqReady); end
    total++; if (clearDone !== 1'b0) begin bad++; $display("FAIL midclr_done got=%b want=0", clearDone); end
    wq.delete(); done_q.delete();
    repeat (5) step();
    total++;
    if (wq.size() != 0 || done_q.size() != 0) begin
      bad++; $display("FAIL midclr_quiet got=%0d writes %0d pulses want=0 0", wq.size(), done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_big(0, 0, 5);
    test_big(W - 1, H - 1, 6);
    test_big(130, 200, 2);
    test_big(int'($urandom_range(1, W - 2)), int'($urandom_range(1, H - 2)), int'($urandom_range(0, 7)));
    test_back_to_back(16, 1'b0);
    test_back_to_back(STAMP_CYCLES_BIG * 4, 1'b1);
    test_clear();
    test_clear_during_stamp();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
